alu_mul_sequencer: RTL and testbench

- Multi-cycle sequencer that computes the low 32 bits of a 32x32 multiply using the shared ALU in add mode (shift-and-add).
- Sits beside the single-cycle datapath and borrows the ALU through a req/gnt handshake, so the datapath keeps priority.
- Exposes a start/busy/done interface to the control unit.
- Returns the product and N/Z flags in the same bit order as the ALU flags.

---
 rtl/alu_mul_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_mul_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add 32x32 low-half multiplier that borrows the shared ALU
module alu_mul_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [3:0]       mul_flags,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  // Iteration counter only has to reach WIDTH-1; it may wrap afterwards.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mplier_next;
  logic             last_iter;

  // {N,Z,C,V} in ALU flag order; the multiply never reports carry or overflow.
  function automatic logic [3:0] flags_of(input logic [WIDTH-1:0] p);
    return {p[WIDTH-1], (p == '0), 2'b00};
  endfunction

  // The ALU always sees the accumulator and the shifted multiplicand; only add mode is used.
  assign alu_a    = acc;
  assign alu_b    = mcand;
  assign alu_ctrl = 2'b00;

  // Next-iteration values and the exit decision, all based on the current multiplier LSB.
  always_comb begin
    acc_next    = mplier[0] ? alu_result : acc;
    mplier_next = mplier >> 1;
    last_iter   = (EARLY_EXIT && (mplier_next == '0)) || (count == LAST_ITER);
  end

  // Sequencer FSM: capture on start, commit one iteration per granted cycle, pulse done once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      product   <= '0;
      mul_flags <= 4'b0100;
      busy      <= 1'b0;
      done      <= 1'b0;
      alu_req   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= a_in;
            mplier <= b_in;
            acc    <= '0;
            count  <= '0;
            if (EARLY_EXIT && (b_in == '0)) begin
              // Nothing to add: finish immediately with a zero product.
              product   <= '0;
              mul_flags <= 4'b0100;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              busy    <= 1'b1;
              alu_req <= 1'b1;
              state   <= S_RUN;
            end
          end
        end

        S_RUN: begin
          // Without a grant the datapath owns the ALU; hold everything and retry.
          if (alu_gnt) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier_next;
            count  <= count + CW'(1);
            if (last_iter) begin
              product   <= acc_next;
              mul_flags <= flags_of(acc_next);
              busy      <= 1'b0;
              alu_req   <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          alu_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - bench for alu_mul_sequencer against a plain-arithmetic reference
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;

  logic        start;
  logic [31:0] a_in, b_in;
  logic        busy, done, alu_req, gnt;
  logic [31:0] product, alu_a, alu_b, alu_result;
  logic [3:0]  mul_flags;
  logic [1:0]  alu_ctrl;

  logic        start0;
  logic [31:0] a0, b0;
  logic        busy0, done0, req0, gnt0;
  logic [31:0] product0, alu_a0, alu_b0, alu_result0;
  logic [3:0]  flags0;
  logic [1:0]  ctrl0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in for the shared ALU in add mode.
  assign alu_result  = alu_a + alu_b;
  assign alu_result0 = alu_a0 + alu_b0;

  alu_mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product), .mul_flags(mul_flags),
    .alu_req(alu_req), .alu_gnt(gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );

  alu_mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .a_in(a0), .b_in(b0),
    .busy(busy0), .done(done0), .product(product0), .mul_flags(flags0),
    .alu_req(req0), .alu_gnt(gnt0), .alu_a(alu_a0), .alu_b(alu_b0),
    .alu_ctrl(ctrl0), .alu_result(alu_result0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Number of granted iterations needed: highest set bit + 1, or the full width.
  function automatic int ref_k(input logic [31:0] b, input bit ee);
    if (!ee) return 32;
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [3:0] ref_flags(input logic [31:0] p);
    return {p[31], (p == 32'd0), 2'b00};
  endfunction

  // gmode: 0 = grant always, 1 = random grant, 2 = grant withheld for five RUN edges.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int gmode, input int exp_lat, input bit extra,
                         output int busy_cycles);
    int k, lat, granted, pred;
    bit seen, busy_bad;
    logic [31:0] p;
    p       = a * b;
    k       = ref_k(b, 1'b1);
    pred    = (k == 0) ? 1 : -1;
    lat     = 0;
    granted = 0;
    seen    = 1'b0;
    busy_bad = 1'b0;
    busy_cycles = 0;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    gnt   = 1'b1;
    while (lat < 300 && !seen) begin
      @(posedge clk);
      lat++;
      if (lat >= 2 && gnt && pred < 0) begin
        granted++;
        if (granted == k) pred = lat;
      end
      #1;
      start = extra && (lat == 2);
      if (extra && lat == 2) begin
        a_in = 32'd7;
        b_in = 32'd9;
      end
      seen = done;
      if (!seen) begin
        if (busy !== (k > 0) || alu_req !== (k > 0)) busy_bad = 1'b1;
        if (busy === 1'b1) busy_cycles++;
      end else if (busy !== 1'b0 || alu_req !== 1'b0) begin
        busy_bad = 1'b1;
      end
      case (gmode)
        1:       gnt = ($urandom_range(0, 3) != 0);
        2:       gnt = !(lat >= 2 && lat <= 6);
        default: gnt = 1'b1;
      endcase
    end
    start = 1'b0;
    gnt   = 1'b1;
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, lat, pred);
    if (exp_lat > 0) check({tag, ".latency_abs"}, lat, exp_lat);
    check({tag, ".product"}, product, p);
    check({tag, ".flags"}, 32'(mul_flags), 32'(ref_flags(p)));
    check({tag, ".busy_req"}, 32'(busy_bad), 32'd0);
    step();
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".product_held"}, product, p);
  endtask

  // Fixed-length variant for the instance that never exits early.
  task automatic run_mul0(input string tag, input logic [31:0] a, input logic [31:0] b);
    int lat;
    int run_cycles;
    bit seen;
    lat = 0;
    run_cycles = 0;
    seen = 1'b0;
    a0 = a;
    b0 = b;
    start0 = 1'b1;
    while (lat < 300 && !seen) begin
      step();
      lat++;
      start0 = 1'b0;
      seen = done0;
      if (busy0 === 1'b1) run_cycles++;
    end
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, lat, 33);
    check({tag, ".run_cycles"}, run_cycles, 32);
    check({tag, ".product"}, product0, a * b);
    step();
  endtask

  initial begin
    int bc;
    int done_cnt;
    logic [31:0] ra, rb;

    reset = 1'b1;
    start = 1'b0;  a_in = '0; b_in = '0; gnt = 1'b1;
    start0 = 1'b0; a0 = '0;   b0 = '0;   gnt0 = 1'b1;
    step();
    step();
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.req", 32'(alu_req), 32'd0);
    check("rst.product", product, 32'd0);
    check("rst.flags", 32'(mul_flags), 32'h4);
    check("rst.acc", alu_a, 32'd0);
    check("rst.mcand", alu_b, 32'd0);
    check("rst.ctrl", 32'(alu_ctrl), 32'd0);
    check("rst0.flags", 32'(flags0), 32'h4);
    reset = 1'b0;
    step();

    run_mul("t1", 32'd7, 32'd6, 0, 4, 1'b0, bc);
    check("t1.busy_cycles", bc, 3);
    run_mul("t2", 32'h12345678, 32'd0, 0, 1, 1'b0, bc);
    check("t2.busy_cycles", bc, 0);
    run_mul("t3", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 33, 1'b0, bc);
    check("t3.busy_cycles", bc, 32);
    run_mul0("t3_noexit", 32'h89ABCDEF, 32'd1);
    run_mul("t4a", 32'h00010000, 32'h00010000, 0, 0, 1'b0, bc);
    run_mul("t4b", 32'h40000000, 32'd2, 0, 3, 1'b0, bc);
    run_mul("t5", 32'd100, 32'd25, 2, 11, 1'b1, bc);

    // Abort in the third RUN cycle of 3*0xF0.
    a_in = 32'd3; b_in = 32'hF0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6.busy", 32'(busy), 32'd0);
    check("t6.req", 32'(alu_req), 32'd0);
    check("t6.done", 32'(done), 32'd0);
    check("t6.product", product, 32'd0);
    check("t6.flags", 32'(mul_flags), 32'h4);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    check("t6.no_done", done_cnt, 0);
    run_mul("t6_after", 32'd3, 32'd5, 0, 4, 1'b0, bc);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 8 == 3) rb = 32'd0;
      run_mul($sformatf("rnd%0d", i), ra, rb, 1, 0, (i % 3 == 0), bc);
    end
    run_mul0("rnd_noexit", $urandom, $urandom);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
